// File: rtl/perceptron_seq.sv
// Sequential online perceptron that predicts the next button bit from a shift history of past bits.
// One shared datapath walks the taps serially: weight update, squared norm, optional halving, history shift, dot product.
module perceptron_seq #(
  parameter int          N_TAPS   = 20,
  parameter int          WW       = 10,
  parameter int          ETA      = 2,
  parameter logic [23:0] GAMMA_SQ = 24'd500000
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          busy,
  output logic          pred,
  output logic          pred_valid,
  output logic [WW-1:0] y,
  output logic          ovf,
  output logic [7:0]    led
);

  localparam int ACC_W = 16;
  localparam int IW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IW-1:0]            LAST   = IW'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (WW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [ACC_W-1:0] ETA_S  = ACC_W'(ETA);

  typedef enum logic [2:0] {IDLE, UPDATE, NORM, SCALE, SHIFT, PREDICT, DONE} state_t;

  // Symmetric clamp: the most negative code is never produced, so negation stays safe.
  function automatic logic signed [WW-1:0] sat_ww(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > SAT_HI)      c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    else                 c = v;
    return c[WW-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [WW-1:0]    w_q [N_TAPS];
  logic signed [WW-1:0]    w_d [N_TAPS];
  logic [N_TAPS-1:0]       xh_q, xh_d;
  logic                    xin_q, xin_d;
  logic                    pend_q, pend_d;
  logic                    pend_bit_q, pend_bit_d;
  logic [23:0]             norm_q, norm_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [WW-1:0]    y_q, y_d;
  logic                    pred_q, pred_d;
  logic                    pred_valid_q, pred_valid_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic                    armed_q, armed_d;
  logic [6:0]              hits_q, hits_d;

  logic signed [WW-1:0]    w_cur;
  logic signed [2*WW-1:0]  sq;
  logic signed [ACC_W-1:0] w_ext;
  logic                    accept_new;
  logic                    nb;

  assign w_cur      = w_q[idx_q];
  assign sq         = w_cur * w_cur;
  assign w_ext      = ACC_W'(w_cur);
  // armed_q masks the first edge after reset release so a coincident pulse is ignored.
  assign accept_new = armed_q && in_valid;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    for (int i = 0; i < N_TAPS; i++) w_d[i] = w_q[i];
    xh_d         = xh_q;
    xin_d        = xin_q;
    pend_d       = pend_q;
    pend_bit_d   = pend_bit_q;
    norm_d       = norm_q;
    acc_d        = acc_q;
    y_d          = y_q;
    pred_d       = pred_q;
    pred_valid_d = 1'b0;
    ovf_d        = ovf_q;
    hits_d       = hits_q;
    armed_d      = 1'b1;
    nb           = pend_q ? pend_bit_q : in_bit;

    if (state_q != IDLE && accept_new) begin
      if (!pend_q) begin
        pend_d     = 1'b1;
        pend_bit_d = in_bit;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q || accept_new) begin
          xin_d   = nb;
          state_d = UPDATE;
          idx_d   = '0;
          if (nb == pred_q && hits_q != 7'h7f) hits_d = hits_q + 7'd1;
          // A pulse arriving while the buffered event drains takes its slot.
          pend_d = pend_q && accept_new;
          if (pend_q && accept_new) pend_bit_d = in_bit;
        end
      end
      UPDATE: begin
        w_d[idx_q] = sat_ww(w_ext + ((xin_q == xh_q[idx_q]) ? ETA_S : -ETA_S));
        idx_d      = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) state_d = NORM;
      end
      NORM: begin
        norm_d = ((idx_q == '0) ? 24'd0 : norm_q) + 24'($unsigned(sq));
        idx_d  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) state_d = SCALE;
      end
      SCALE: begin
        if (norm_q > GAMMA_SQ)
          for (int i = 0; i < N_TAPS; i++) w_d[i] = w_q[i] >>> 1;
        state_d = SHIFT;
      end
      SHIFT: begin
        xh_d    = {xh_q[N_TAPS-2:0], xin_q};
        state_d = PREDICT;
      end
      PREDICT: begin
        acc_d = ((idx_q == '0) ? '0 : acc_q) + (xh_q[idx_q] ? w_ext : -w_ext);
        idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        y_d          = sat_ww(acc_q);
        pred_d       = !acc_q[ACC_W-1];
        pred_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stay busy across the IDLE slot that drains a buffered event.
    busy_d = (state_d != IDLE) || pend_d;
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      for (int i = 0; i < N_TAPS; i++) w_q[i] <= '0;
      xh_q         <= '0;
      xin_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_bit_q   <= 1'b0;
      norm_q       <= '0;
      acc_q        <= '0;
      y_q          <= '0;
      pred_q       <= 1'b0;
      pred_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      armed_q      <= 1'b0;
      hits_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      for (int i = 0; i < N_TAPS; i++) w_q[i] <= w_d[i];
      xh_q         <= xh_d;
      xin_q        <= xin_d;
      pend_q       <= pend_d;
      pend_bit_q   <= pend_bit_d;
      norm_q       <= norm_d;
      acc_q        <= acc_d;
      y_q          <= y_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      armed_q      <= armed_d;
      hits_q       <= hits_d;
    end
  end

  assign busy       = busy_q;
  assign pred       = pred_q;
  assign pred_valid = pred_valid_q;
  assign y          = y_q;
  assign ovf        = ovf_q;
  assign led        = {pred_q, hits_q};

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: default-threshold instance a, low-threshold (GAMMA_SQ=80) instance b.
module tb_perceptron_seq;

  logic CLOCK_50 = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;

  logic busy_a, pred_a, pv_a, ovf_a;
  logic signed [9:0] y_a;
  logic [7:0] led_a;
  logic busy_b, pred_b, pv_b, ovf_b;
  logic signed [9:0] y_b;
  logic [7:0] led_b;

  int checks = 0;
  int failures = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  perceptron_seq a (
    .CLOCK_50(CLOCK_50), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy_a), .pred(pred_a), .pred_valid(pv_a), .y(y_a), .ovf(ovf_a), .led(led_a)
  );

  perceptron_seq #(.GAMMA_SQ(24'd80)) b (
    .CLOCK_50(CLOCK_50), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .busy(busy_b), .pred(pred_b), .pred_valid(pv_b), .y(y_b), .ovf(ovf_b), .led(led_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send(input logic bval);
    in_valid = 1'b1;
    in_bit   = bval;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_pv(output int n);
    n = 0;
    while (pv_a !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    int n;
    int pv_cnt, first_pv, second_pv, busy_gaps;
    int bad_lat, bad_y, bad_w;

    // Reset state
    tick(3);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_pv", 32'(pv_a), 0);
    check("rst_y", 32'(y_a), 0);
    check("rst_led", 32'(led_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);

    // Pulse coincident with reset release is ignored
    rst = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    check("rel_pulse_ignored", 32'(busy_a), 0);

    // First event: bit 1
    send(1'b1);
    wait_pv(n);
    check("ev1_latency", n, 63);
    check("ev1_y", 32'(y_a), 36);
    check("ev1_pred", 32'(pred_a), 1);
    check("ev1_led", 32'(led_a), 32'h80);
    check("ev1_y_b", 32'(y_b), 36);
    check("ev1_w0", 32'(a.w_q[0]), -2);
    check("ev1_w19", 32'(a.w_q[19]), -2);
    check("ev1_xh", 32'(a.xh_q), 1);
    tick(1);
    check("ev1_pv_width", 32'(pv_a), 0);

    // Second event: bit 1; instance b halves its weights
    send(1'b1);
    wait_pv(n);
    check("ev2_latency", n, 63);
    check("ev2_y", 32'(y_a), 68);
    check("ev2_led", 32'(led_a), 32'h81);
    check("ev2_w0", 32'(a.w_q[0]), 0);
    check("ev2_w1", 32'(a.w_q[1]), -4);
    check("ev2_y_b", 32'(y_b), 34);
    check("ev2_w0_b", 32'(b.w_q[0]), 0);
    check("ev2_w1_b", 32'(b.w_q[1]), -2);
    check("ev2_led_b", 32'(led_b), 32'h81);

    // Reset in the middle of PREDICT
    tick(1);
    send(1'b1);
    tick(50);
    rst = 1'b1;
    #1;
    check("midrst_y", 32'(y_a), 0);
    check("midrst_led", 32'(led_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_pv", 32'(pv_a), 0);
    check("midrst_w5", 32'(a.w_q[5]), 0);
    tick(2);
    rst = 1'b0;
    pv_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (pv_a === 1'b1) pv_cnt++;
    end
    check("midrst_no_pv", pv_cnt, 0);
    send(1'b1);
    wait_pv(n);
    check("post_rst_latency", n, 63);
    check("post_rst_y", 32'(y_a), 36);
    check("post_rst_led", 32'(led_a), 32'h80);
    tick(1);

    // Three pulses within 10 cycles: one processed, one buffered, one dropped
    pv_cnt = 0;
    first_pv = -1;
    second_pv = -1;
    busy_gaps = 0;
    for (int k = 0; k < 200; k++) begin
      in_valid = (k == 0) || (k == 3) || (k == 6);
      in_bit   = (k == 3);
      tick(1);
      if (pv_a === 1'b1) begin
        pv_cnt++;
        if (first_pv < 0) first_pv = k;
        else if (second_pv < 0) second_pv = k;
      end
      if (second_pv < 0 && busy_a !== 1'b1) busy_gaps++;
    end
    in_valid = 1'b0;
    check("burst_pv_count", pv_cnt, 2);
    check("burst_first_pv", first_pv, 63);
    check("burst_second_pv", second_pv, 127);
    check("burst_busy_gaps", busy_gaps, 0);
    check("burst_busy_end", 32'(busy_a), 0);
    check("burst_ovf", 32'(ovf_a), 1);

    // Long run of ones: hits and weights saturate, y stays in range
    do_reset();
    check("ovf_cleared", 32'(ovf_a), 0);
    bad_lat = 0;
    bad_y = 0;
    for (int k = 0; k < 200; k++) begin
      send(1'b1);
      wait_pv(n);
      if (n != 63) bad_lat++;
      if (y_a == -10'sd512) bad_y++;
      tick(1);
    end
    bad_w = 0;
    for (int i = 0; i < 20; i++) if (a.w_q[i] == -10'sd512) bad_w++;
    check("long_latency", bad_lat, 0);
    check("long_y_range", bad_y, 0);
    check("long_w_range", bad_w, 0);
    check("long_hits_sat", 32'(led_a[6:0]), 127);
    check("long_pred", 32'(pred_a), 1);
    check("long_ovf", 32'(ovf_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perceptron_seq.md
PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

Interface
REQ-001 Parameter N_TAPS, default 20, number of history taps and weights.
REQ-002 Parameter WW, default 10, signed weight width.
REQ-003 Parameter ETA, default 2, signed learning step added per tap per update.
REQ-004 Parameter GAMMA_SQ, default 24'd500000, unsigned squared-norm threshold.
REQ-005 CLOCK_50  in  1  sole clock, all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  single-cycle pulse, one debounced button event.
REQ-008 in_bit  in  1  event value (k1=1, k2=0), sampled with in_valid.
REQ-009 busy  out  1  high whenever FSM is not IDLE.
REQ-010 pred  out  1  current prediction of the next bit.
REQ-011 pred_valid  out  1  one-cycle pulse, new pred/y valid.
REQ-012 y  out  WW  signed dot product, saturated to [-511,511].
REQ-013 ovf  out  1  sticky, an input event was lost.
REQ-014 led  out  8  {pred, hits[6:0]}; hits = saturating count of correct predictions.

Function
REQ-015 Block shall own weight array w[N_TAPS] (signed WW) and history register xh[N_TAPS]; xh[0] newest; bit b maps to s(b)=+1 if 1, -1 if 0.
REQ-016 FSM states: IDLE, UPDATE, NORM, SCALE, SHIFT, PREDICT, DONE; each of UPDATE, NORM, PREDICT lasts exactly N_TAPS cycles (index 0..N_TAPS-1); SCALE, SHIFT, DONE one cycle each.
REQ-017 IDLE: if pending buffer full, consume it; else if in_valid, accept in_bit; either case latch bit as xin, go UPDATE; pending has priority over a same-cycle in_valid, which then refills pending.
REQ-018 On leaving IDLE: hits += 1 (saturate at 127) if xin == pred.
REQ-019 UPDATE, tap i: w[i] <= sat(w[i] + ETA*s(xin)*s(xh[i])), saturation range [-511,511].
REQ-020 NORM: acc24 = sum of w[i]^2 over all taps, unsigned 24-bit, cleared on entry.
REQ-021 SCALE: if acc24 > GAMMA_SQ, all w[i] <= w[i] >>> 1 (arithmetic) in one cycle; else unchanged.
REQ-022 SHIFT: xh <= {xh[N_TAPS-2:0], xin}.
REQ-023 PREDICT: 16-bit signed acc = sum w[i]*s(xh[i]), cleared on entry.
REQ-024 DONE: y <= sat(acc), pred <= (acc >= 0), pred_valid=1 this cycle only; next state IDLE.
REQ-025 Latency: pred_valid asserted exactly 63 cycles after the accepting edge (N_TAPS=20); IDLE-to-IDLE throughput 64 cycles.
REQ-026 in_valid while busy: stored in one-deep pending buffer if empty; if full, event dropped and ovf set.
REQ-027 ovf cleared only by rst.

Reset
REQ-028 rst shall immediately force: state IDLE, all w=0, xh=0, xin=0, pending empty, acc=0, y=0, pred=0, pred_valid=0, busy=0, hits=0, ovf=0; any in-flight operation aborted, no pred_valid emitted.
REQ-029 in_valid coincident with rst deassertion edge shall be ignored.

Verification
REQ-030 Reset, in_bit=1 pulse -> hits=0, all w[1..19]=-2, w[0]=-2, xh=...001, y=36, pred=1, pred_valid exactly 63 cycles later, led=8'h80.
REQ-031 GAMMA_SQ=80: bits 1 then 1 -> after 2nd: acc24=304>80, halved: w[0]=0, w[1..19]=-2; hits=1.
REQ-032 Three in_valid pulses within 10 cycles -> first processed, second pending then processed, third dropped; exactly two pred_valid pulses, ovf=1, busy continuous 128 cycles.
REQ-033 rst asserted in PREDICT (cycle 50 after acceptance) -> all outputs zero next edge, no pred_valid, following bit behaves as REQ-030.
REQ-034 200 consecutive in_bit=1 events -> hits saturates at 127 (no wrap), every w[i] clamps at ≤511, y never outside [-511,511].
